// File: rtl/csr_pkg.sv
// Shared definitions for the CSR read-modify-write unit: operation encodings
// (RISC-V funct3 of the SYSTEM/CSR instructions) and the CSR address width.
package csr_pkg;

    localparam int ADDR_W = 12;
    localparam int OP_W   = 3;

    // funct3 codes; 000 and 100 are not CSR instructions and report an error
    typedef enum logic [OP_W-1:0] {
        CSR_ILL0 = 3'b000,
        CSR_RW   = 3'b001,
        CSR_RS   = 3'b010,
        CSR_RC   = 3'b011,
        CSR_ILL4 = 3'b100,
        CSR_RWI  = 3'b101,
        CSR_RSI  = 3'b110,
        CSR_RCI  = 3'b111
    } csr_op_e;

endpackage

// File: rtl/csr_rmw_unit_if.sv
// Request/response bundle between the issue stage (master) and the CSR unit (slave).
interface csr_rmw_unit_if #(
    parameter int XLEN = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic [csr_pkg::OP_W-1:0]  req_op;
    logic [csr_pkg::ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]           req_rs1;
    logic                      req_rs1_x0;
    logic [4:0]                req_zimm;
    logic                      flush;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [XLEN-1:0]           rsp_rdata;
    logic                      rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_rs1, req_rs1_x0, req_zimm, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_rs1, req_rs1_x0, req_zimm, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/csr_op_alu.sv
// Combinational CSR operation: new value, write intent and illegal-op detection.
// Write intent ignores address/read-only checks; the caller folds those in.
module csr_op_alu
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] src_val,
    input  logic            src_zero,
    output logic [XLEN-1:0] new_val,
    output logic            wen,
    output logic            op_illegal
);

    // set/clear with a zero source must not write (no side effects on read-only CSRs)
    always_comb begin
        new_val    = old_val;
        wen        = 1'b0;
        op_illegal = 1'b0;
        case (csr_op_e'(op))
            CSR_RW, CSR_RWI: begin
                new_val = src_val;
                wen     = 1'b1;
            end
            CSR_RS, CSR_RSI: begin
                new_val = old_val | src_val;
                wen     = !src_zero;
            end
            CSR_RC, CSR_RCI: begin
                new_val = old_val & ~src_val;
                wen     = !src_zero;
            end
            default: op_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/csr_rmw_unit.sv
// CSR array with a single-entry response stage. The new value is computed at
// accept time and only written to the array when the response is taken by WB
// without a flush. A request accepted on that same edge sees the committed value.
module csr_rmw_unit
    import csr_pkg::*;
#(
    parameter int                 XLEN    = 32,
    parameter int                 NUM_CSR = 8,
    parameter logic [NUM_CSR-1:0] RO_MASK = '0
) (
    input logic          clk,
    input logic          rst_n,
    csr_rmw_unit_if.slave bus
);

    localparam int              IDX_W     = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;
    localparam logic [ADDR_W-1:0] NUM_CSR_A = ADDR_W'(NUM_CSR);

    logic [XLEN-1:0]  csr_q [NUM_CSR];
    logic [XLEN-1:0]  csr_d [NUM_CSR];
    logic             s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
    logic [XLEN-1:0]  s1_rdata_q, s1_rdata_d;
    logic [XLEN-1:0]  s1_new_q, s1_new_d;
    logic             s1_wen_q, s1_wen_d;
    logic             s1_err_q, s1_err_d;

    logic [IDX_W-1:0] req_idx;
    logic [XLEN-1:0]  src_val;
    logic             src_zero;
    logic [XLEN-1:0]  old_val;
    logic [XLEN-1:0]  alu_new;
    logic             alu_wen;
    logic             alu_illegal;
    logic             req_err;
    logic             accept;
    logic             commit;

    assign req_idx  = bus.req_addr[IDX_W-1:0];
    assign src_val  = bus.req_op[2] ? XLEN'(bus.req_zimm) : bus.req_rs1;
    assign src_zero = bus.req_op[2] ? (bus.req_zimm == 5'd0) : bus.req_rs1_x0;

    // a stalled response blocks new requests unless a flush frees the stage
    assign bus.req_ready = !s1_valid_q || bus.rsp_ready || bus.flush;
    assign accept        = bus.req_valid && bus.req_ready;
    assign commit        = s1_valid_q && bus.rsp_ready && !bus.flush && s1_wen_q;

    // forward the value being committed this edge so back-to-back RMW is exact
    assign old_val = (commit && (s1_idx_q == req_idx)) ? s1_new_q : csr_q[req_idx];

    csr_op_alu #(.XLEN(XLEN)) u_alu (
        .op         (bus.req_op),
        .old_val    (old_val),
        .src_val    (src_val),
        .src_zero   (src_zero),
        .new_val    (alu_new),
        .wen        (alu_wen),
        .op_illegal (alu_illegal)
    );

    assign req_err = alu_illegal || (bus.req_addr >= NUM_CSR_A) || (RO_MASK[req_idx] && alu_wen);

    assign bus.rsp_valid = s1_valid_q;
    assign bus.rsp_rdata = s1_rdata_q;
    assign bus.rsp_err   = s1_err_q;

    // stage-1 next state and array write
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_idx_d   = s1_idx_q;
        s1_rdata_d = s1_rdata_q;
        s1_new_d   = s1_new_q;
        s1_wen_d   = s1_wen_q;
        s1_err_d   = s1_err_q;
        csr_d      = csr_q;

        if (s1_valid_q && (bus.rsp_ready || bus.flush)) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_idx_d   = req_idx;
            s1_rdata_d = req_err ? '0 : old_val;
            s1_new_d   = alu_new;
            s1_wen_d   = alu_wen && !req_err;
            s1_err_d   = req_err;
        end
        if (commit) begin
            csr_d[s1_idx_q] = s1_new_q;
        end
    end

    // state registers; reset drops any in-flight entry and clears the array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CSR; i++) begin
                csr_q[i] <= '0;
            end
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_rdata_q <= '0;
            s1_new_q   <= '0;
            s1_wen_q   <= 1'b0;
            s1_err_q   <= 1'b0;
        end else begin
            csr_q      <= csr_d;
            s1_valid_q <= s1_valid_d;
            s1_idx_q   <= s1_idx_d;
            s1_rdata_q <= s1_rdata_d;
            s1_new_q   <= s1_new_d;
            s1_wen_q   <= s1_wen_d;
            s1_err_q   <= s1_err_d;
        end
    end

endmodule
